// File: rtl/autosa_cdp_rdma_grp_pkg.sv
// Shared status encoding and FSM state type for the CDP RDMA ping-pong group controller.
package autosa_cdp_rdma_grp_pkg;

  localparam logic [1:0] StatIdle    = 2'd0;
  localparam logic [1:0] StatRunning = 2'd1;
  localparam logic [1:0] StatPending = 2'd2;
  localparam logic [1:0] StatError   = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun,
    StDone
  } grp_state_e;

endpackage

// File: rtl/autosa_cdp_rdma_grp_wdog.sv
// Run-phase timeout counter; only instantiated when AUTOSA_CDP_RDMA_GRP_WDOG_EN is defined.
module autosa_cdp_rdma_grp_wdog
  import autosa_cdp_rdma_grp_pkg::*;
#(
  parameter int unsigned WDOG_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic hit
);

  localparam int unsigned CntW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

  logic [CntW-1:0] cnt;

  // Cleared on the launch-accept edge so the first RUN cycle sees a count of zero.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = run && (cnt == CntW'(WDOG_CYC - 1));

endmodule

// File: rtl/autosa_cdp_rdma_grp_ctrl.sv
// Two-group ping-pong launch controller for the CDP RDMA datapath.
// Define AUTOSA_CDP_RDMA_GRP_WDOG_EN to add the run-phase watchdog.
module autosa_cdp_rdma_grp_ctrl
  import autosa_cdp_rdma_grp_pkg::*;
#(
  parameter int unsigned WDOG_CYC = 1024
) (
  input  logic       autosa_core_clk,
  input  logic       autosa_core_rst,
  input  logic       producer,
  input  logic       op_en_wr,
  input  logic       dp_op_ready,
  input  logic       dp_done,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic [1:0] op_en,
  output logic       dp_op_valid,
  output logic       dp_op_grp,
  output logic [1:0] irq,
  output logic       err,
  output logic       wdog_err
);

  grp_state_e      state;
  logic [1:0][1:0] grp_status;
  logic            wdog_exp;
  logic            accept;
  logic            clr_match;
  logic            wr_ok;
  logic            wr_dup;
  logic            stray_done;

  assign status_0 = grp_status[0];
  assign status_1 = grp_status[1];

  always_comb begin
    accept     = (state == StLaunch) && dp_op_valid && dp_op_ready;
    // A write landing on the group being cleared re-arms it instead of counting as a duplicate.
    clr_match  = ((state == StDone) || wdog_exp) && (producer == dp_op_grp);
    wr_ok      = op_en_wr && (!op_en[producer] || clr_match);
    wr_dup     = op_en_wr && !wr_ok;
    stray_done = dp_done && (state != StRun);
  end

`ifdef AUTOSA_CDP_RDMA_GRP_WDOG_EN
  logic wdog_hit;

  autosa_cdp_rdma_grp_wdog #(
    .WDOG_CYC(WDOG_CYC)
  ) u_wdog (
    .clk  (autosa_core_clk),
    .rst  (autosa_core_rst),
    .start(accept),
    .run  (state == StRun),
    .hit  (wdog_hit)
  );

  // A completion arriving on the expiry cycle wins over the timeout.
  assign wdog_exp = wdog_hit && !dp_done;

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_exp;
    end
  end
`else
  assign wdog_exp = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      state       <= StIdle;
      consumer    <= 1'b0;
      op_en       <= '0;
      grp_status  <= '0;
      dp_op_valid <= 1'b0;
      dp_op_grp   <= 1'b0;
      irq         <= '0;
      err         <= 1'b0;
    end else begin
      irq <= '0;
      err <= wr_dup || stray_done;

      unique case (state)
        StIdle: begin
          if (op_en[consumer]) begin
            state       <= StLaunch;
            dp_op_valid <= 1'b1;
            dp_op_grp   <= consumer;
          end
        end
        StLaunch: begin
          if (accept) begin
            state                 <= StRun;
            dp_op_valid           <= 1'b0;
            grp_status[dp_op_grp] <= StatRunning;
          end
        end
        StRun: begin
          if (dp_done) begin
            state <= StDone;
          end else if (wdog_exp) begin
            state                 <= StIdle;
            op_en[dp_op_grp]      <= 1'b0;
            grp_status[dp_op_grp] <= StatError;
            consumer              <= ~consumer;
          end
        end
        StDone: begin
          state                 <= StIdle;
          op_en[dp_op_grp]      <= 1'b0;
          grp_status[dp_op_grp] <= StatIdle;
          irq[dp_op_grp]        <= 1'b1;
          consumer              <= ~consumer;
        end
        default: state <= StIdle;
      endcase

      // Placed after the FSM so a same-cycle re-enable overrides the completion clear.
      if (wr_ok) begin
        op_en[producer]      <= 1'b1;
        grp_status[producer] <= StatPending;
      end
    end
  end

endmodule

// File: tb/tb_autosa_cdp_rdma_grp_ctrl.sv
// Directed bench for autosa_cdp_rdma_grp_ctrl; watchdog steps follow AUTOSA_CDP_RDMA_GRP_WDOG_EN.
module tb_autosa_cdp_rdma_grp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       producer;
  logic       op_en_wr;
  logic       dp_op_ready;
  logic       dp_done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic [1:0] op_en;
  logic       dp_op_valid;
  logic       dp_op_grp;
  logic [1:0] irq;
  logic       err;
  logic       wdog_err;

  int vectors     = 0;
  int miscompares = 0;

  autosa_cdp_rdma_grp_ctrl #(
    .WDOG_CYC(16)
  ) dut (
    .autosa_core_clk(clk),
    .autosa_core_rst(rst),
    .producer       (producer),
    .op_en_wr       (op_en_wr),
    .dp_op_ready    (dp_op_ready),
    .dp_done        (dp_done),
    .consumer       (consumer),
    .status_0       (status_0),
    .status_1       (status_1),
    .op_en          (op_en),
    .dp_op_valid    (dp_op_valid),
    .dp_op_grp      (dp_op_grp),
    .irq            (irq),
    .err            (err),
    .wdog_err       (wdog_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_consumer"}, {31'd0, consumer}, 32'd0);
    check({tag, "_op_en"}, {30'd0, op_en}, 32'd0);
    check({tag, "_status"}, {28'd0, status_1, status_0}, 32'd0);
    check({tag, "_valid_grp"}, {30'd0, dp_op_valid, dp_op_grp}, 32'd0);
    check({tag, "_irq_err"}, {28'd0, irq, err, wdog_err}, 32'd0);
  endtask

  task automatic write_en(input logic grp);
    producer = grp;
    op_en_wr = 1'b1;
    tick(1);
    op_en_wr = 1'b0;
  endtask

  task automatic pulse_done();
    dp_done = 1'b1;
    tick(1);
    dp_done = 1'b0;
  endtask

  initial begin
    logic seen_valid;
    rst         = 1'b1;
    producer    = 1'b0;
    op_en_wr    = 1'b0;
    dp_op_ready = 1'b0;
    dp_done     = 1'b0;
    tick(2);
    check_reset("reset");
    rst = 1'b0;

    // Single operation, ready offered only in the LAUNCH cycle.
    write_en(1'b0);
    check("single_op_en", {30'd0, op_en}, 32'h1);
    check("single_pending", {30'd0, status_0}, 32'd2);
    check("single_no_valid_yet", {31'd0, dp_op_valid}, 32'd0);
    tick(1);
    check("single_valid", {30'd0, dp_op_valid, dp_op_grp}, 32'b10);
    dp_op_ready = 1'b1;
    tick(1);
    dp_op_ready = 1'b0;
    check("single_accepted", {31'd0, dp_op_valid}, 32'd0);
    check("single_running", {30'd0, status_0}, 32'd1);
    tick(6);
    pulse_done();
    check("single_done_no_irq_yet", {30'd0, irq}, 32'd0);
    tick(1);
    check("single_irq", {30'd0, irq}, 32'b01);
    check("single_consumer", {31'd0, consumer}, 32'd1);
    check("single_status", {30'd0, status_0}, 32'd0);
    check("single_op_en_clr", {30'd0, op_en}, 32'd0);
    tick(1);
    check("single_irq_pulse", {30'd0, irq}, 32'd0);

    // Ping-pong with both groups enabled and ready held high.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    dp_op_ready = 1'b1;
    write_en(1'b0);
    write_en(1'b1);
    check("pp_both_en", {30'd0, op_en}, 32'b11);
    check("pp_launch0", {30'd0, dp_op_valid, dp_op_grp}, 32'b10);
    tick(1);
    pulse_done();
    tick(1);
    check("pp_irq0", {30'd0, irq}, 32'b01);
    check("pp_consumer1", {31'd0, consumer}, 32'd1);
    check("pp_idle_gap", {31'd0, dp_op_valid}, 32'd0);
    tick(1);
    check("pp_launch1", {30'd0, dp_op_valid, dp_op_grp}, 32'b11);
    tick(1);
    check("pp_running1", {30'd0, status_1}, 32'd1);
    pulse_done();
    tick(1);
    check("pp_irq1", {30'd0, irq}, 32'b10);
    check("pp_consumer0", {31'd0, consumer}, 32'd0);
    check("pp_status", {28'd0, status_1, status_0}, 32'd0);

    // Group 1 alone must not launch while consumer is 0.
    write_en(1'b1);
    check("ooo_status1", {30'd0, status_1}, 32'd2);
    seen_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      seen_valid = seen_valid | dp_op_valid;
    end
    check("ooo_no_launch", {31'd0, seen_valid}, 32'd0);
    check("ooo_status1_held", {30'd0, status_1}, 32'd2);

    write_en(1'b1);
    check("dup_err", {31'd0, err}, 32'd1);
    check("dup_state", {26'd0, op_en, status_1, status_0}, 32'b10_10_00);
    tick(1);
    check("dup_err_pulse", {31'd0, err}, 32'd0);

    pulse_done();
    check("stray_done_err", {31'd0, err}, 32'd1);
    check("stray_done_no_irq", {30'd0, irq}, 32'd0);

    // Re-enable group 0 during its own DONE cycle.
    write_en(1'b0);
    tick(1);
    check("dcw_launch0", {30'd0, dp_op_valid, dp_op_grp}, 32'b10);
    tick(1);
    pulse_done();
    write_en(1'b0);
    check("dcw_op_en_kept", {30'd0, op_en}, 32'b11);
    check("dcw_pending", {30'd0, status_0}, 32'd2);
    check("dcw_irq_no_err", {29'd0, irq, err}, 32'b010);
    check("dcw_consumer", {31'd0, consumer}, 32'd1);
    tick(1);
    check("dcw_launch1", {30'd0, dp_op_valid, dp_op_grp}, 32'b11);
    tick(1);
    pulse_done();
    tick(1);
    check("dcw_irq1", {30'd0, irq}, 32'b10);
    check("dcw_op_en0_left", {30'd0, op_en}, 32'b01);
    tick(1);
    check("dcw_relaunch0", {30'd0, dp_op_valid, dp_op_grp}, 32'b10);
    tick(1);
    check("dcw_running0", {30'd0, status_0}, 32'd1);

    // Reset during RUN abandons the operation.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("run_reset");
    pulse_done();
    check("post_reset_done_err", {31'd0, err}, 32'd1);
    check("post_reset_done_no_irq", {30'd0, irq}, 32'd0);

    // Watchdog behaviour with done withheld; RUN is entered at the third edge.
    write_en(1'b0);
    tick(2);
    check("wd_running", {30'd0, status_0}, 32'd1);
`ifdef AUTOSA_CDP_RDMA_GRP_WDOG_EN
    tick(15);
    check("wd_not_yet", {31'd0, wdog_err}, 32'd0);
    tick(1);
    check("wd_fire", {31'd0, wdog_err}, 32'd1);
    check("wd_status_err", {30'd0, status_0}, 32'd3);
    check("wd_cleanup", {28'd0, op_en, irq}, 32'd0);
    check("wd_consumer", {31'd0, consumer}, 32'd1);
    tick(1);
    check("wd_pulse", {31'd0, wdog_err}, 32'd0);
    write_en(1'b0);
    check("wd_err_cleared", {30'd0, status_0}, 32'd2);
`else
    tick(40);
    check("nowd_still_running", {30'd0, status_0}, 32'd1);
    check("nowd_no_wdog_err", {31'd0, wdog_err}, 32'd0);
    check("nowd_no_irq", {29'd0, irq, consumer}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/autosa_cdp_rdma_grp_ctrl.md
AUTOSA_CDP_RDMA_GRP_CTRL -- requirements
Module: autosa_cdp_rdma_grp_ctrl

Interface
REQ-001 SHALL have parameter WDOG_CYC, default 1024: run-timeout limit in cycles; only used with the watchdog configured in.
REQ-002 SHALL have port autosa_core_clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port autosa_core_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port producer  input  1  group software is programming (register-file producer flop).
REQ-005 SHALL have port op_en_wr  input  1  one-cycle pulse: software wrote op_en=1 to group producer.
REQ-006 SHALL have port dp_op_ready  input  1  datapath accepts a launch.
REQ-007 SHALL have port dp_done  input  1  one-cycle pulse: launched operation finished.
REQ-008 SHALL have port consumer  output  1  group next to execute or executing.
REQ-009 SHALL have port status_0 / status_1  output  2 each  per-group status.
REQ-010 SHALL have port op_en  output  2  per-group enable flags.
REQ-011 SHALL have port dp_op_valid  output  1  launch request, level.
REQ-012 SHALL have port dp_op_grp  output  1  group being launched/run.
REQ-013 SHALL have port irq  output  2  one-cycle per-group completion pulse.
REQ-014 SHALL have port err  output  1  one-cycle protocol-error pulse.
REQ-015 SHALL have port wdog_err  output  1  one-cycle timeout pulse.

Function
REQ-016 Status encoding SHALL be 0 IDLE, 1 RUNNING, 2 PENDING, 3 ERROR.
REQ-017 op_en_wr at edge N SHALL set op_en[producer] at N+1; status of that group becomes PENDING at N+1.
REQ-018 op_en_wr to a group whose op_en is already 1 SHALL be ignored; err pulses at N+1.
REQ-019 FSM states SHALL be IDLE, LAUNCH, RUN, DONE.
REQ-020 IDLE->LAUNCH when op_en[consumer]=1; op_en of the other group alone never launches (strict ping-pong order).
REQ-021 In LAUNCH, dp_op_valid=1 and dp_op_grp=consumer. On dp_op_valid&dp_op_ready -> RUN; group status becomes RUNNING. dp_op_valid SHALL NOT drop before acceptance.
REQ-022 In RUN, dp_done -> DONE.
REQ-023 DONE lasts one cycle. It clears op_en[dp_op_grp], sets that status to IDLE, pulses irq[dp_op_grp], and toggles consumer, then goes to IDLE.
REQ-024 op_en_wr to the completing group in the DONE cycle SHALL take priority over the clear: op_en stays 1 and status is PENDING.
REQ-025 dp_done outside RUN SHALL be ignored and SHALL pulse err.
REQ-026 Minimum launch latency SHALL be 2 cycles from op_en_wr to dp_op_valid: op_en at N+1, LAUNCH at N+2.
REQ-027 Back-to-back: with both groups enabled, the second LAUNCH SHALL follow DONE by one IDLE cycle.

Reset
REQ-028 On autosa_core_rst the block SHALL enter FSM IDLE with consumer=0, op_en=0, status_0=status_1=0, dp_op_valid=0, dp_op_grp=0, irq=0, err=0, wdog_err=0, and the watchdog counter at 0.
REQ-029 Reset mid-LAUNCH or mid-RUN SHALL abandon the operation with no irq.

Configuration
REQ-030 Macro AUTOSA_CDP_RDMA_GRP_WDOG_EN SHALL select the run watchdog.
REQ-031 With the macro defined: a counter clears on entry to RUN and increments each RUN cycle. When it reaches WDOG_CYC-1 without dp_done, the controller pulses wdog_err, sets the group status to ERROR, clears its op_en, toggles consumer, and returns to IDLE with no irq. ERROR is cleared by the next op_en_wr to that group.
REQ-032 Without the macro: no counter, wdog_err is tied to 0, status never reaches 3, and RUN waits indefinitely.

Structure
REQ-033 Package autosa_cdp_rdma_grp_pkg SHALL hold the status encoding constants and the FSM state enum.
REQ-034 The watchdog SHALL be sub-module autosa_cdp_rdma_grp_wdog, instantiated only under the macro.

Verification
REQ-035 Single op: producer=0, op_en_wr -> dp_op_valid at +2, ready at +3, dp_done at +10 -> irq=2'b01 for one cycle, consumer=1, status_0=0.
REQ-036 Ping-pong: enable groups 0 then 1 -> launches dp_op_grp 0 then 1 in order; irq 01 then 10; consumer returns to 0.
REQ-037 Out-of-order enable: only group 1 enabled while consumer=0 -> dp_op_valid stays 0 for 50 cycles; status_1=2.
REQ-038 Errors: duplicate op_en_wr to a pending group -> err pulse, state unchanged. Stray dp_done in IDLE -> err pulse. Same-cycle op_en_wr during DONE -> status=2.
REQ-039 Watchdog with macro, WDOG_CYC=16, dp_done withheld -> wdog_err at RUN cycle 15, status=3, no irq. Without the macro -> no change.
REQ-040 Reset asserted during RUN -> all outputs at reset values next cycle; a later dp_done produces err, not irq.
